// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the multi-cycle single-precision adder:
//   - IEEE-754 single field widths and special encodings
//   - sequencer state encoding
//   - classification of the outcome of the mantissa add step
//   - unpacked operand record used by the align unit
//   - NaN / infinity classification helpers
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int          EXP_W    = 8;
   localparam int          MAN_W    = 23;
   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Result class decided by the add step and consumed by the normaliser.
   typedef enum logic [1:0] {
      ADD_NORMAL = 2'd0,
      ADD_ZERO   = 2'd1,
      ADD_INF    = 2'd2
   } add_kind_t;

   // Sign, biased exponent and 24-bit mantissa with the hidden bit explicit.
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W:0]   man;
   } unpacked_t;

   function automatic logic is_nan(input logic [31:0] v);
      return (v[30:23] == EXP_W'(EXP_MAX)) && (v[22:0] != '0);
   endfunction

   function automatic logic is_inf(input logic [31:0] v);
      return (v[30:23] == EXP_W'(EXP_MAX)) && (v[22:0] == '0);
   endfunction

endpackage

// File: rtl/fp_align_unit.sv
// -----------------------------------------------------------------------------
// fp_align_unit
// Combinational unpack / swap / alignment for one addition.
//   a, b           : raw IEEE-754 single operands
//   x_sign/exp/man : larger-magnitude operand (hidden bit explicit)
//   y_sign/y_man   : smaller operand, mantissa shifted right to x's exponent
//   special        : NaN or infinity involved; result is special_val
//   special_val    : QNAN, or the infinity that dominates the sum
//   neg_zero       : both operands are (flushed) negative zeros
// Denormal inputs are flushed to signed zero. Alignment truncates, so the
// adder rounds toward zero.
// -----------------------------------------------------------------------------
module fp_align_unit
   import fp_pkg::*;
(
   input  logic [31:0]    a,
   input  logic [31:0]    b,
   output logic           x_sign,
   output logic [EXP_W-1:0] x_exp,
   output logic [MAN_W:0] x_man,
   output logic           y_sign,
   output logic [MAN_W:0] y_man,
   output logic           special,
   output logic [31:0]    special_val,
   output logic           neg_zero
);

   logic [31:0] op   [2];
   unpacked_t   u    [2];
   logic [30:0] mag  [2];

   assign op[0] = a;
   assign op[1] = b;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         logic normal;
         assign normal  = (op[gi][30:23] != '0);
         assign u[gi]   = {op[gi][31], op[gi][30:23],
                           normal ? {1'b1, op[gi][22:0]} : 24'd0};
         // Magnitude key with denormals already collapsed to zero.
         assign mag[gi] = normal ? op[gi][30:0] : 31'd0;
      end
   endgenerate

   unpacked_t       x_op;
   unpacked_t       y_op;
   logic [EXP_W-1:0] shift_d;

   always_comb begin
      if (mag[1] > mag[0]) begin
         x_op = u[1];
         y_op = u[0];
      end else begin
         x_op = u[0];
         y_op = u[1];
      end
   end

   // Never negative: x has the larger {exp,mant}, and a zero y has exp 0.
   assign shift_d = x_op.exp - y_op.exp;

   assign x_sign = x_op.sign;
   assign x_exp  = x_op.exp;
   assign x_man  = x_op.man;
   assign y_sign = y_op.sign;
   assign y_man  = (shift_d >= 8'd25) ? '0 : (y_op.man >> shift_d);

   logic nan_any;
   logic inf_a;
   logic inf_b;

   assign nan_any = is_nan(a) | is_nan(b);
   assign inf_a   = is_inf(a);
   assign inf_b   = is_inf(b);
   assign special = nan_any | inf_a | inf_b;

   always_comb begin
      if (nan_any || (inf_a && inf_b && (a[31] != b[31])))
         special_val = QNAN;
      else if (inf_a)
         special_val = a;
      else
         special_val = b;
   end

   assign neg_zero = (mag[0] == '0) && (mag[1] == '0) && a[31] && b[31];

endmodule

// File: rtl/fp_add_sequencer.sv
// -----------------------------------------------------------------------------
// fp_add_sequencer
// Multi-cycle IEEE-754 single-precision adder: one shared 25-bit
// adder/subtractor and a 1-bit-per-cycle normalising shifter.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B latched on acceptance)
//   out_valid/out_ready : result handshake (Sum held while out_valid)
//   busy                : any state other than IDLE
// Sequence: IDLE -> ALIGN -> ADD -> NORM (shifts+1 cycles) -> DONE.
// NaN/infinity cases leave ALIGN straight for DONE. The zero and overflow
// outcomes found by the add step are resolved on the first NORM evaluation,
// so every arithmetic outcome shares the same minimum latency.
// All outputs are registered.
// -----------------------------------------------------------------------------
module fp_add_sequencer
   import fp_pkg::*;
#(
   parameter int MAX_NORM = 24
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Sum,
   output logic        busy
);

   localparam int CNT_W = $clog2(MAX_NORM + 1);

   state_t            state_reg;
   logic [31:0]       a_reg;
   logic [31:0]       b_reg;
   logic              x_sign_reg;
   logic [EXP_W-1:0]  x_exp_reg;
   logic [MAN_W:0]    x_man_reg;
   logic              y_sign_reg;
   logic [MAN_W:0]    y_man_reg;
   logic              neg_zero_reg;
   logic              work_sign_reg;
   logic [EXP_W-1:0]  work_exp_reg;
   logic [MAN_W:0]    work_man_reg;
   add_kind_t         add_kind_reg;
   logic [CNT_W-1:0]  norm_cnt_reg;
   logic [31:0]       sum_reg;
   logic              out_valid_reg;
   logic              in_ready_reg;
   logic              busy_reg;

   // Alignment of the latched operands.
   logic              al_x_sign;
   logic [EXP_W-1:0]  al_x_exp;
   logic [MAN_W:0]    al_x_man;
   logic              al_y_sign;
   logic [MAN_W:0]    al_y_man;
   logic              al_special;
   logic [31:0]       al_special_val;
   logic              al_neg_zero;

   fp_align_unit u_align (
      .a           (a_reg),
      .b           (b_reg),
      .x_sign      (al_x_sign),
      .x_exp       (al_x_exp),
      .x_man       (al_x_man),
      .y_sign      (al_y_sign),
      .y_man       (al_y_man),
      .special     (al_special),
      .special_val (al_special_val),
      .neg_zero    (al_neg_zero)
   );

   // Shared adder/subtractor; subtraction never underflows because x is
   // the larger magnitude.
   logic [24:0]       add_sum_next;
   logic [MAN_W:0]    add_man_next;
   logic [EXP_W-1:0]  add_exp_next;
   add_kind_t         add_kind_next;

   always_comb begin
      if (x_sign_reg == y_sign_reg)
         add_sum_next = {1'b0, x_man_reg} + {1'b0, y_man_reg};
      else
         add_sum_next = {1'b0, x_man_reg} - {1'b0, y_man_reg};

      add_man_next  = add_sum_next[24] ? add_sum_next[24:1] : add_sum_next[23:0];
      add_exp_next  = add_sum_next[24] ? (x_exp_reg + 8'd1) : x_exp_reg;
      add_kind_next = ADD_NORMAL;
      if (add_sum_next == '0)
         add_kind_next = ADD_ZERO;
      else if (add_sum_next[24] && (x_exp_reg == 8'd254))
         add_kind_next = ADD_INF;
   end

   // Normaliser decision for the current NORM cycle.
   logic              norm_done_next;
   logic [31:0]       norm_sum_next;

   always_comb begin
      norm_done_next = 1'b1;
      norm_sum_next  = '0;
      case (add_kind_reg)
         ADD_ZERO: norm_sum_next = {neg_zero_reg, 31'd0};
         ADD_INF:  norm_sum_next = {work_sign_reg, 8'hFF, 23'd0};
         default: begin
            if (work_man_reg[23])
               norm_sum_next = {work_sign_reg, work_exp_reg, work_man_reg[22:0]};
            else if ((work_exp_reg <= 8'd1) || (norm_cnt_reg == CNT_W'(MAX_NORM)))
               // Another shift would need a denormal exponent: flush.
               norm_sum_next = {work_sign_reg, 31'd0};
            else
               norm_done_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         x_sign_reg    <= 1'b0;
         x_exp_reg     <= '0;
         x_man_reg     <= '0;
         y_sign_reg    <= 1'b0;
         y_man_reg     <= '0;
         neg_zero_reg  <= 1'b0;
         work_sign_reg <= 1'b0;
         work_exp_reg  <= '0;
         work_man_reg  <= '0;
         add_kind_reg  <= ADD_NORMAL;
         norm_cnt_reg  <= '0;
         sum_reg       <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid && in_ready_reg) begin
                  a_reg        <= A;
                  b_reg        <= B;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ALIGN;
               end
            end
            ALIGN: begin
               if (al_special) begin
                  sum_reg       <= al_special_val;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  x_sign_reg   <= al_x_sign;
                  x_exp_reg    <= al_x_exp;
                  x_man_reg    <= al_x_man;
                  y_sign_reg   <= al_y_sign;
                  y_man_reg    <= al_y_man;
                  neg_zero_reg <= al_neg_zero;
                  state_reg    <= ADD;
               end
            end
            ADD: begin
               work_sign_reg <= x_sign_reg;
               work_exp_reg  <= add_exp_next;
               work_man_reg  <= add_man_next;
               add_kind_reg  <= add_kind_next;
               norm_cnt_reg  <= '0;
               state_reg     <= NORM;
            end
            NORM: begin
               if (norm_done_next) begin
                  sum_reg       <= norm_sum_next;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  work_man_reg <= {work_man_reg[22:0], 1'b0};
                  work_exp_reg <= work_exp_reg - 8'd1;
                  norm_cnt_reg <= norm_cnt_reg + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign Sum       = sum_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp_add_sequencer
// Directed vectors for fp_add_sequencer with hand-computed sums and
// latencies. Latency n means out_valid is first sampled high by edge T+n,
// where T is the operand handshake edge. Outputs are sampled on the falling
// edge; inputs change on the falling edge or just after a rising edge.
// -----------------------------------------------------------------------------
module tb_fp_add_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Sum;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   fp_add_sequencer #(.MAX_NORM(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One add: handshake, keep in_valid high with junk operands while busy,
   // measure latency, then hold out_ready low for 'hold' cycles.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_sum, input int exp_lat, input int hold);
      int lat;
      bit seen;
      @(negedge clk);
      out_ready = (hold == 0);
      A         = a;
      B         = b;
      in_valid  = 1'b1;
      check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      A = 32'h7FC0_1234;
      B = ~b;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 64) begin
         @(negedge clk);
         lat++;
         if (out_valid) seen = 1'b1;
         else check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      end
      in_valid = 1'b0;
      check({tag, "_seen"}, {31'd0, seen}, 32'd1);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_sum"}, Sum, exp_sum);
      $display("op %s A=0x%08h B=0x%08h Sum=0x%08h lat=%0d", tag, a, b, Sum, lat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_sum"}, Sum, exp_sum);
         check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      bit stale;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = '0;
      B         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum",       Sum,                32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      rst = 1'b0;

      run_op("one_plus_one",  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, 0);
      run_op("one_minus_075", 32'h3F80_0000, 32'hBF40_0000, 32'h3E80_0000, 6, 0);
      run_op("swap_order",    32'hBF40_0000, 32'h3F80_0000, 32'h3E80_0000, 6, 0);
      run_op("neg_result",    32'hBF80_0000, 32'h3F40_0000, 32'hBE80_0000, 6, 0);
      run_op("cancel",        32'h4040_0000, 32'hC040_0000, 32'h0000_0000, 4, 0);
      run_op("negz_negz",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4, 0);
      run_op("posz_negz",     32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4, 0);
      run_op("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4, 0);
      run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2, 0);
      run_op("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2, 0);
      run_op("inf_plus_one",  32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 2, 0);
      run_op("ninf_ninf",     32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 2, 0);
      run_op("gap24",         32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4, 0);
      run_op("denorm_flush",  32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 4, 0);
      run_op("underflow",     32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 4, 0);
      run_op("norm23",        32'h3F80_0000, 32'hBF7F_FFFF, 32'h3400_0000, 27, 0);
      run_op("backpressure",  32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, 5);

      // Reset in the middle of a long normalise.
      @(negedge clk);
      A        = 32'h3F80_0000;
      B        = 32'hBF7F_FFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("midop_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
      check("midrst_busy",      {31'd0, busy},      32'd0);
      check("midrst_sum",       Sum,                32'd0);
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("midrst_no_output", {31'd0, stale}, 32'd0);
      check("midrst_sum_after", Sum, 32'd0);
      $display("op reset_mid_norm out_valid_seen=%0d Sum=0x%08h", stale, Sum);

      run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Multi-cycle controller for IEEE-754 single-precision addition with valid/ready handshakes on input and output.
- Sequences the add in four steps: unpack/align, mantissa add/subtract, iterative normalise, pack.
- Sits between operand producers (register file / ALU decode) and the result writeback path.
- Trades latency for area: one shared 25-bit adder/subtractor and a 1-bit-per-cycle normalise shifter.

Parameters:
- MAX_NORM, 24, maximum left-shift iterations in NORM; a safety bound that must be greater than or equal to mantissa width + 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  operands A/B present
- in_ready  out  1  block can accept operands
- A  in  32  IEEE-754 single operand
- B  in  32  IEEE-754 single operand
- out_valid  out  1  Sum valid
- out_ready  in  1  consumer accepts Sum
- Sum  out  32  IEEE-754 single result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_valid=0; Sum=0; busy=0; in_ready=1.
  - Reset wins over every other event, including mid-operation; any in-flight op is discarded and produces no output.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- in_ready=1 only in IDLE. A handshake (in_valid & in_ready) at edge T latches A and B, and state becomes ALIGN.
- ALIGN (1 cycle):
  - Unpack sign, exponent and mantissa; hidden bit is 1 when exp!=0.
  - exp==0 inputs are flushed to zero (denormals are treated as 0).
  - Swap so that operand X has the larger magnitude (compare {exp,mant}).
  - Shift Y mantissa right by d = expX - expY. If d>=25, Y becomes 0. Truncate with no guard/sticky bits; rounding is toward zero.
- ADD (1 cycle):
  - Same signs: 25-bit sum = mX + mY. Different signs: mX - mY, which is never negative.
  - Result sign = sign of X.
  - If bit24 is set: shift right 1 and exp+1.
  - If exp reaches 255: result is +/-inf and the block goes to DONE directly.
  - A zero mantissa goes to DONE with Sum=+0. The result is -0 only if both inputs were -0.
  - Otherwise go to NORM.
- NORM:
  - Each cycle, if bit23==0: shift left 1 and exp-1.
  - If bit23==1: pack and go to DONE.
  - If exp would reach 0 before bit23==1, flush to signed zero and go to DONE (no denormal output).
  - Cycles spent in NORM = shifts + 1, with at most MAX_NORM+1.
- DONE:
  - out_valid=1; Sum is stable for as long as out_valid is held.
  - When out_valid & out_ready: state=IDLE and out_valid=0 on the next edge.
  - No bypass: a new input cannot be accepted in the same cycle as the output handshake.
- Latency: handshake at edge T gives out_valid high from T+4+k, where k = normalise shifts (k=0 for the zero and inf paths).
- Specials (detected in ALIGN, then go straight to DONE at T+2):
  - Any NaN input, or +inf + -inf: Sum=0x7FC00000.
  - One inf input: that inf is the result.
  - Two like-signed infs: that inf is the result.
- in_valid while busy is ignored; A and B may change freely outside the handshake.
- Throughput: one op in flight at a time.

Decomposition:
- Shared package fp_pkg holds:
  - localparams EXP_W=8, MAN_W=23, EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
  - State encoding enum: IDLE=0, ALIGN=1, ADD=2, NORM=3, DONE=4.
  - Function is_nan, function is_inf.
- One natural sub-module, fp_align_unit: combinational unpack/swap/right-shift, instantiated inside the sequencer.
- The FSM, adder, normaliser and pack logic stay in fp_add_sequencer.

Test Plan:
- 1.0 + 1.0: A=0x3F800000, B=0x3F800000, handshake at T → Sum=0x40000000 with out_valid first high at T+4.
- 1.0 + -0.75: A=0x3F800000, B=0xBF400000 → Sum=0x3E800000 at T+6 (k=2); busy stays high through NORM.
- Full cancellation: A=0x40400000, B=0xC0400000 → Sum=0x00000000 at T+4; separately, -0 + -0 → 0x80000000.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000 at T+2.
  - Large exponent gap, 0x4B800000 + 0x3F800000 (d=24) → 0x4B800000 (truncated).
- Backpressure: hold out_ready=0 for 5 cycles → out_valid and Sum stay stable and in_ready=0; raising out_ready completes the handshake, and in_ready=1 on the next cycle.
- Reset mid-op: assert rst during NORM → next cycle state=IDLE, out_valid=0, in_ready=1; no stale Sum appears afterward.
